// File: rtl/mips_decode_npc.sv
// Single-cycle MIPS control slice: instruction decode, immediate extension,
// next-PC selection and the PC register itself.
module mips_decode_npc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4,
    output logic [31:0] imm32,
    output logic        reg_dst,
    output logic        link,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        memto_reg,
    output logic        alu_src,
    output logic        alu_a_src,
    output logic [3:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic [1:0]  npc_op,
    output logic        shift_index,
    output logic        shift_right,
    output logic        shift_arith
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_PASSA = 4'b1001;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [15:0] imm_s;
    logic [25:0] target_s;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] imm32_s;
    logic [31:0] npc_s;

    logic        reg_dst_s;
    logic        link_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        memto_reg_s;
    logic        alu_src_s;
    logic        alu_a_src_s;
    logic [3:0]  alu_op_s;
    logic [1:0]  ext_op_s;
    logic [1:0]  npc_op_s;
    logic        shift_index_s;
    logic        shift_right_s;
    logic        shift_arith_s;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] result;
        case (mode)
            EXT_ZERO:  result = {16'h0000, imm};
            EXT_SIGN:  result = {{16{imm[15]}}, imm};
            EXT_UPPER: result = {imm, 16'h0000};
            default:   result = {16'h0000, imm};
        endcase
        return result;
    endfunction

    assign op_s     = instr[31:26];
    assign funct_s  = instr[5:0];
    assign imm_s    = instr[15:0];
    assign target_s = instr[25:0];

    // Main decoder: opcode/funct to datapath controls, everything defaults to 0
    always_comb begin
        reg_dst_s     = 1'b0;
        link_s        = 1'b0;
        reg_write_s   = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        memto_reg_s   = 1'b0;
        alu_src_s     = 1'b0;
        alu_a_src_s   = 1'b0;
        alu_op_s      = ALU_ADD;
        ext_op_s      = EXT_ZERO;
        npc_op_s      = NPC_SEQ;
        shift_index_s = 1'b0;
        shift_right_s = 1'b0;
        shift_arith_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
                case (funct_s)
                    6'h20, 6'h21: alu_op_s = ALU_ADD;
                    6'h22, 6'h23: alu_op_s = ALU_SUB;
                    6'h24:        alu_op_s = ALU_AND;
                    6'h25:        alu_op_s = ALU_OR;
                    6'h26:        alu_op_s = ALU_XOR;
                    6'h27:        alu_op_s = ALU_NOR;
                    6'h2A:        alu_op_s = ALU_SLT;
                    6'h2B:        alu_op_s = ALU_SLTU;
                    // Shifts route the shifter result through ALU A unchanged
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        alu_a_src_s   = 1'b1;
                        alu_op_s      = ALU_PASSA;
                        shift_index_s = funct_s[2];
                        shift_right_s = funct_s[1];
                        shift_arith_s = funct_s[1] & funct_s[0];
                    end
                    6'h08: begin
                        reg_write_s = 1'b0;
                        npc_op_s    = NPC_REG;
                    end
                    default: reg_write_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_ADD; ext_op_s = EXT_SIGN;
            end
            OP_SLTI: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_SLT; ext_op_s = EXT_SIGN;
            end
            OP_SLTIU: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_SLTU; ext_op_s = EXT_SIGN;
            end
            OP_ANDI: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_AND; ext_op_s = EXT_ZERO;
            end
            OP_ORI: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_OR; ext_op_s = EXT_ZERO;
            end
            OP_XORI: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_XOR; ext_op_s = EXT_ZERO;
            end
            OP_LUI: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_ADD; ext_op_s = EXT_UPPER;
            end
            OP_LW: begin
                alu_src_s = 1'b1; reg_write_s = 1'b1;
                alu_op_s = ALU_ADD; ext_op_s = EXT_SIGN;
                mem_read_s = 1'b1; memto_reg_s = 1'b1;
            end
            OP_SW: begin
                alu_src_s = 1'b1; mem_write_s = 1'b1;
                alu_op_s = ALU_ADD; ext_op_s = EXT_SIGN;
            end
            OP_BEQ: begin
                alu_op_s = ALU_SUB; ext_op_s = EXT_SIGN;
                npc_op_s = zero ? NPC_BRANCH : NPC_SEQ;
            end
            OP_BNE: begin
                alu_op_s = ALU_SUB; ext_op_s = EXT_SIGN;
                npc_op_s = zero ? NPC_SEQ : NPC_BRANCH;
            end
            OP_J: npc_op_s = NPC_JUMP;
            OP_JAL: begin
                npc_op_s    = NPC_JUMP;
                link_s      = 1'b1;
                reg_write_s = 1'b1;
            end
            default: npc_op_s = NPC_SEQ;
        endcase
    end

    assign pc_plus4_s = pc_r + 32'd4;
    assign imm32_s    = extend_imm(imm_s, ext_op_s);

    // Next-PC selection; all additions wrap modulo 2^32
    always_comb begin
        npc_s = pc_plus4_s;
        case (npc_op_s)
            NPC_SEQ:    npc_s = pc_plus4_s;
            NPC_BRANCH: npc_s = pc_plus4_s + {imm32_s[29:0], 2'b00};
            NPC_JUMP:   npc_s = {pc_plus4_s[31:28], target_s, 2'b00};
            NPC_REG:    npc_s = rs_data;
            default:    npc_s = pc_plus4_s;
        endcase
    end

    // PC register; reset clears it immediately and drops any pending npc
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= 32'h0000_0000;
        end else begin
            pc_r <= npc_s;
        end
    end

    assign pc          = pc_r;
    assign npc         = npc_s;
    assign pc_plus4    = pc_plus4_s;
    assign imm32       = imm32_s;
    assign reg_dst     = reg_dst_s;
    assign link        = link_s;
    // Architectural state writes are blocked while reset is held
    assign reg_write   = reg_write_s & rst;
    assign mem_write   = mem_write_s & rst;
    assign mem_read    = mem_read_s;
    assign memto_reg   = memto_reg_s;
    assign alu_src     = alu_src_s;
    assign alu_a_src   = alu_a_src_s;
    assign alu_op      = alu_op_s;
    assign ext_op      = ext_op_s;
    assign npc_op      = npc_op_s;
    assign shift_index = shift_index_s;
    assign shift_right = shift_right_s;
    assign shift_arith = shift_arith_s;

endmodule

// File: tb/tb_mips_decode_npc.sv
// Directed-vector bench for mips_decode_npc with hand-computed expectations.
module tb_mips_decode_npc;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] pc, npc, pc_plus4, imm32;
    logic        reg_dst, link, reg_write, mem_read, mem_write, memto_reg;
    logic        alu_src, alu_a_src, shift_index, shift_right, shift_arith;
    logic [3:0]  alu_op;
    logic [1:0]  ext_op, npc_op;

    int total_cnt = 0;
    int bad_cnt   = 0;

    mips_decode_npc dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .rs_data(rs_data),
        .pc(pc), .npc(npc), .pc_plus4(pc_plus4), .imm32(imm32),
        .reg_dst(reg_dst), .link(link), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .memto_reg(memto_reg),
        .alu_src(alu_src), .alu_a_src(alu_a_src), .alu_op(alu_op),
        .ext_op(ext_op), .npc_op(npc_op), .shift_index(shift_index),
        .shift_right(shift_right), .shift_arith(shift_arith)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        instr   = 32'h2008_0005;
        zero    = 1'b0;
        rs_data = 32'h0;
        #3;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_regwrite", {31'd0, reg_write}, 32'd0);
        tick();
        check_eq("rst_hold_pc", pc, 32'h0);

        // Release away from the edge; addi decodes with writes enabled
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("addi_imm", imm32, 32'h5);
        check_eq("addi_alusrc", {31'd0, alu_src}, 32'd1);
        check_eq("addi_ext", {30'd0, ext_op}, 32'd1);
        check_eq("addi_regwrite", {31'd0, reg_write}, 32'd1);
        check_eq("addi_aluop", {28'd0, alu_op}, 32'd0);
        check_eq("addi_regdst", {31'd0, reg_dst}, 32'd0);
        tick();
        check_eq("first_edge_pc", pc, 32'h4);
        tick(); tick(); tick();
        check_eq("seq_pc", pc, 32'h10);

        // Branch at pc=0x10
        instr = 32'h1109_FFFC;
        zero  = 1'b1;
        #1;
        check_eq("beq_taken_npc", npc, 32'h4);
        check_eq("beq_taken_op", {30'd0, npc_op}, 32'd1);
        check_eq("beq_regwrite", {31'd0, reg_write}, 32'd0);
        zero = 1'b0;
        #1;
        check_eq("beq_nt_npc", npc, 32'h14);
        instr = 32'h1509_FFFC;
        #1;
        check_eq("bne_taken_npc", npc, 32'h4);
        instr = 32'h1109_FFFC;
        tick();
        check_eq("beq_nt_pc", pc, 32'h14);
        instr = 32'h2008_0005;
        tick(); tick(); tick();
        check_eq("pre_jal_pc", pc, 32'h20);

        // jal then jr
        instr = 32'h0C00_0010;
        #1;
        check_eq("jal_npc", npc, 32'h40);
        check_eq("jal_link", {31'd0, link}, 32'd1);
        check_eq("jal_regwrite", {31'd0, reg_write}, 32'd1);
        check_eq("jal_pcplus4", pc_plus4, 32'h24);
        tick();
        check_eq("jal_pc", pc, 32'h40);
        instr   = 32'h03E0_0008;
        rs_data = 32'h24;
        #1;
        check_eq("jr_npc", npc, 32'h24);
        check_eq("jr_regwrite", {31'd0, reg_write}, 32'd0);
        check_eq("jr_op", {30'd0, npc_op}, 32'd3);
        tick();
        check_eq("jr_pc", pc, 32'h24);

        // Memory
        instr = 32'h8C0A_0008;
        #1;
        check_eq("lw_memread", {31'd0, mem_read}, 32'd1);
        check_eq("lw_memtoreg", {31'd0, memto_reg}, 32'd1);
        check_eq("lw_imm", imm32, 32'h8);
        instr = 32'hAC0A_0008;
        #1;
        check_eq("sw_memwrite", {31'd0, mem_write}, 32'd1);
        check_eq("sw_regwrite", {31'd0, reg_write}, 32'd0);

        // Extension modes
        instr = 32'h3108_FFFF;
        #1;
        check_eq("andi_zext", imm32, 32'h0000_FFFF);
        check_eq("andi_aluop", {28'd0, alu_op}, 32'd2);
        instr = 32'h2108_FFFF;
        #1;
        check_eq("addi_sext", imm32, 32'hFFFF_FFFF);
        instr = 32'h3C08_1234;
        #1;
        check_eq("lui_upper", imm32, 32'h1234_0000);
        check_eq("lui_ext", {30'd0, ext_op}, 32'd2);

        // Shifts
        instr = 32'h0009_40C3;
        #1;
        check_eq("sra_flags", {27'd0, alu_a_src, shift_right, shift_arith, shift_index, reg_dst},
                 {27'd0, 5'b11101});
        check_eq("sra_aluop", {28'd0, alu_op}, 32'd9);
        instr = 32'h0009_4004;
        #1;
        check_eq("sllv_flags", {28'd0, shift_index, shift_right, shift_arith, alu_a_src},
                 {28'd0, 4'b1001});

        // Illegal opcode behaves as a NOP
        instr = 32'hFC00_0000;
        #1;
        check_eq("illegal_en", {21'd0, reg_dst, link, reg_write, mem_read, mem_write, memto_reg,
                                alu_src, alu_a_src, shift_index, shift_right, shift_arith}, 32'd0);
        check_eq("illegal_npc", npc, 32'h28);
        check_eq("illegal_op", {30'd0, npc_op}, 32'd0);
        tick();
        check_eq("illegal_pc", pc, 32'h28);

        // Reset asserted mid-cycle
        instr = 32'h2008_0005;
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_regwrite", {31'd0, reg_write}, 32'd0);
        check_eq("midrst_alusrc", {31'd0, alu_src}, 32'd1);
        instr = 32'hAC0A_0008;
        #1;
        check_eq("midrst_memwrite", {31'd0, mem_write}, 32'd0);
        tick();
        check_eq("midrst_hold_pc", pc, 32'h0);
        @(negedge clk);
        rst   = 1'b1;
        instr = 32'h2008_0005;
        tick();
        check_eq("post_rst_pc", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
